// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller with architectural HI/LO registers.
// Fixed-latency MULT/DIV sequencing, MTHI/MTLO writes and a HI/LO read port.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        hilo_sel,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] hilo_rd
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [1:0]  kind;

  logic        is_md;
  logic        accept;
  logic        finish;
  logic        mt_hi;
  logic        mt_lo;

  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_div;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        div_zero;

  // Request decode: ops 0..3 are MULT/DIV, 4/5 are MTHI/MTLO, 6/7 do nothing.
  always_comb begin
    is_md  = ~op[2];
    accept = (state == IDLE) & start & is_md;
    finish = (state == RUN) & (cnt <= 4'd1);
    mt_hi  = (state == IDLE) & start & (op == 3'd4);
    mt_lo  = (state == IDLE) & start & (op == 3'd5);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start is ignored while running.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN:  if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs; the accepting cycle stalls too so the requester holds.
  always_comb begin
    busy    = (state == RUN);
    stall   = reset & (busy | (start & is_md));
    hilo_rd = hilo_sel ? hi : lo;
  end

  // Operand capture and latency counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= 4'd0;
      op_a <= 32'd0;
      op_b <= 32'd0;
      kind <= 2'd0;
    end else if (accept) begin
      op_a <= rs_val;
      op_b <= rt_val;
      kind <= op[1:0];
      cnt  <= op[1] ? DIV_N : MULT_N;
    end else if (state == RUN) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Multiply: kind[0] selects unsigned, otherwise sign-extend to 64 bits.
  always_comb begin
    mul_a = kind[0] ? {32'd0, op_a} : {{32{op_a[31]}}, op_a};
    mul_b = kind[0] ? {32'd0, op_b} : {{32{op_b[31]}}, op_b};
    prod  = mul_a * mul_b;
  end

  // Divide on magnitudes, then restore signs; covers 0x80000000 / -1.
  always_comb begin
    a_neg    = ~kind[0] & op_a[31];
    b_neg    = ~kind[0] & op_b[31];
    a_mag    = a_neg ? (32'd0 - op_a) : op_a;
    b_mag    = b_neg ? (32'd0 - op_b) : op_b;
    div_zero = kind[1] & (op_b == 32'd0);
    b_div    = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag    = a_mag / b_div;
    r_mag    = a_mag % b_div;
    quo      = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem      = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  // Result select for the completion write.
  always_comb begin
    if (kind[1]) begin
      res_hi = rem;
      res_lo = quo;
    end else begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
  end

  // HI/LO registers: completion result or MTHI/MTLO data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (finish) begin
      if (!div_zero) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end else begin
      if (mt_hi) hi <= rs_val;
      if (mt_lo) lo <= rs_val;
    end
  end

  // One-cycle done pulse after the completion edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done <= 1'b0;
    end else begin
      done <= finish;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl.
// Random and directed ops against an arithmetic reference model.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hilo_sel;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] hilo_rd;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .rs_val(rs_val),
    .rt_val(rt_val),
    .hilo_sel(hilo_sel),
    .busy(busy),
    .done(done),
    .stall(stall),
    .hi(hi),
    .lo(lo),
    .hilo_rd(hilo_rd)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [2:0] o,
                                input logic [31:0] a,
                                input logic [31:0] b);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd0: begin
        p = sa * sb;
        exp_hi = p[63:32];
        exp_lo = p[31:0];
      end
      3'd1: begin
        up = ua * ub;
        exp_hi = up[63:32];
        exp_lo = up[31:0];
      end
      3'd2: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        exp_hi = r[31:0];
        exp_lo = q[31:0];
      end
      3'd3: if (b != 0) begin
        exp_hi = a % b;
        exp_lo = a / b;
      end
      3'd4: exp_hi = a;
      3'd5: exp_lo = a;
      default: ;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b);
    int n;
    int lim;
    logic exp_stall;
    @(negedge clk);
    start = 1'b1;
    op = o;
    rs_val = a;
    rt_val = b;
    hilo_sel = 1'($urandom);
    exp_stall = (o <= 3'd3);
    #1;
    checks++;
    if (stall !== exp_stall) begin
      errors++;
      $display("FAIL req_stall op=%0d got %b want %b", o, stall, exp_stall);
    end
    model(o, a, b);
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom);
    rs_val = $urandom;
    rt_val = $urandom;
    if (o <= 3'd3) begin
      lim = (o < 3'd2) ? 5 : 10;
      n = 0;
      while (busy === 1'b1 && n < 40) begin
        n++;
        checks++;
        if (done !== 1'b0 || stall !== 1'b1) begin
          errors++;
          $display("FAIL run_flags op=%0d cyc=%0d done=%b stall=%b want 0 1",
                   o, n, done, stall);
        end
        @(negedge clk);
        rs_val = $urandom;
        rt_val = $urandom;
      end
      checks++;
      if (n != lim) begin
        errors++;
        $display("FAIL busy_len op=%0d got %0d want %0d", o, n, lim);
      end
      checks++;
      if (done !== 1'b1) begin
        errors++;
        $display("FAIL done_pulse op=%0d got %b want 1", o, done);
      end
    end else begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL mt_flags op=%0d busy=%b done=%b want 0 0", o, busy, done);
      end
    end
    checks++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL hilo op=%0d a=%h b=%h got %h_%h want %h_%h",
               o, a, b, hi, lo, exp_hi, exp_lo);
    end
    checks++;
    if (hilo_rd !== (hilo_sel ? exp_hi : exp_lo)) begin
      errors++;
      $display("FAIL hilo_rd sel=%b got %h want %h", hilo_sel, hilo_rd,
               hilo_sel ? exp_hi : exp_lo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b1;
    op = 3'd0;
    rs_val = 32'h1234;
    rt_val = 32'h5678;
    hilo_sel = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags busy=%b done=%b stall=%b want 0 0 0",
               busy, done, stall);
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || hilo_rd !== 32'd0) begin
      errors++;
      $display("FAIL reset_hilo got %h %h %h want 0", hi, lo, hilo_rd);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold busy=%b stall=%b want 0 0", busy, stall);
    end
    start = 1'b0;
    #2 reset = 1'b1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
  endtask

  task automatic test_directed();
    do_op(3'd0, 32'hFFFFFFFE, 32'd3);
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
      errors++;
      $display("FAIL mult_neg got %h_%h want ffffffff_fffffffa", hi, lo);
    end
    do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checks++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      errors++;
      $display("FAIL multu_max got %h_%h want fffffffe_00000001", hi, lo);
    end
    do_op(3'd2, 32'hFFFFFFF9, 32'd2);
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      errors++;
      $display("FAIL div_neg got %h_%h want ffffffff_fffffffd", hi, lo);
    end
    do_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
    checks++;
    if (hi !== 32'd0 || lo !== 32'h80000000) begin
      errors++;
      $display("FAIL div_ovf got %h_%h want 00000000_80000000", hi, lo);
    end
    do_op(3'd4, 32'h11, 32'd0);
    do_op(3'd5, 32'h22, 32'd0);
    do_op(3'd3, 32'hDEADBEEF, 32'd0);
    checks++;
    if (hi !== 32'h11 || lo !== 32'h22) begin
      errors++;
      $display("FAIL divu_zero got %h_%h want 00000011_00000022", hi, lo);
    end
    do_op(3'd6, 32'h5555, 32'h1);
    do_op(3'd7, 32'h6666, 32'h2);
  endtask

  task automatic test_mt_read();
    do_op(3'd4, 32'hABCD, 32'd0);
    hilo_sel = 1'b1;
    #1;
    checks++;
    if (hi !== 32'hABCD || hilo_rd !== 32'hABCD) begin
      errors++;
      $display("FAIL mthi_read hi=%h rd=%h want abcd", hi, hilo_rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    int n;
    a = $urandom;
    b = $urandom;
    @(negedge clk);
    start = 1'b1;
    op = 3'd0;
    rs_val = a;
    rt_val = b;
    model(3'd0, a, b);
    @(negedge clk);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 5 || done !== 1'b1 || stall !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first len=%0d done=%b stall=%b want 5 1 1",
               n, done, stall);
    end
    checks++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL b2b_res1 got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept busy=%b done=%b want 1 0", busy, done);
    end
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 5 || done !== 1'b1 || hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL b2b_second len=%0d done=%b got %h_%h want 5 1 %h_%h",
               n, done, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'd0;
      if ($urandom_range(0, 7) == 0) begin
        a = 32'h80000000;
        b = 32'hFFFFFFFF;
      end
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      do_op(o, a, b);
    end
  endtask

  task automatic test_reset_mid_run();
    do_op(3'd4, 32'hCAFE0001, 32'd0);
    do_op(3'd5, 32'hCAFE0002, 32'd0);
    @(negedge clk);
    start = 1'b1;
    op = 3'd2;
    rs_val = 32'd1000;
    rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_run_flags busy=%b done=%b stall=%b want 0 0 0",
               busy, done, stall);
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL rst_run_hilo got %h_%h want 0_0", hi, lo);
    end
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    @(negedge clk);
    #2 reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
        errors++;
        $display("FAIL rst_after cyc=%0d done=%b busy=%b hilo=%h_%h want 0",
                 i, done, busy, hi, lo);
      end
    end
    do_op(3'd1, 32'd6, 32'd7);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mt_read();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
